// File: rtl/precount_pkg.sv
// Shared types and defaults for the preload-counter job arbiter.
package precount_pkg;

    // Arbiter FSM states.
    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StLoad = 3'd1,
        StRun  = 3'd2,
        StRead = 3'd3,
        StDone = 3'd4
    } state_e;

    // Default RUN-cycle budget before a job is aborted by the watchdog.
    localparam logic [8:0] WdLimitDefault = 9'd300;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: ptr names the requester preferred on a tie.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic ptr,
    output logic gnt0,
    output logic gnt1
);

    // Single requester always wins; on a tie ptr picks (0 -> req0, 1 -> req1).
    always_comb begin
        gnt0 = req0 & (~req1 | ~ptr);
        gnt1 = req1 & (~req0 | ptr);
    end

endmodule

// File: rtl/precount_arb.sv
// Arbitrates two requesters onto one external preload counter. A granted job
// loads the counter, runs it until carry (or watchdog), reads it back and
// acknowledges the owner with the captured value and an abort flag.
module precount_arb
    import precount_pkg::*;
#(
    parameter logic [8:0] WD_LIMIT = WdLimitDefault
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] din0,
    input  logic [7:0] din1,
    input  logic       up0,
    input  logic       up1,
    output logic       ack0,
    output logic       ack1,
    output logic       err,
    output logic [7:0] result,
    output logic       busy,
    output logic [7:0] cnt_din,
    output logic       cnt_up,
    output logic       cnt_load,
    output logic       cnt_en,
    output logic       cnt_rdb,
    input  logic       cnt_carry,
    input  logic [7:0] cnt_dout
);

    state_e     state;
    logic       ptr;       // requester preferred on the next tie
    logic       owner;     // requester owning the current job (1 = req1)
    logic       err_pend;  // abort flag carried from RUN exit to DONE
    logic [8:0] run_cnt;
    logic [8:0] run_cnt_inc;
    logic       gnt0;
    logic       gnt1;

    rr_arb2 u_rr_arb2 (
        .req0 (req0),
        .req1 (req1),
        .ptr  (ptr),
        .gnt0 (gnt0),
        .gnt1 (gnt1)
    );

    // Next value of the RUN-cycle counter, used for the watchdog compare.
    always_comb begin
        run_cnt_inc = run_cnt + 9'd1;
    end

    // Job FSM; every output is registered and changes on the state transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            ptr      <= 1'b0;
            owner    <= 1'b0;
            err_pend <= 1'b0;
            run_cnt  <= 9'd0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            err      <= 1'b0;
            result   <= 8'h00;
            busy     <= 1'b0;
            cnt_din  <= 8'h00;
            cnt_up   <= 1'b0;
            cnt_load <= 1'b0;
            cnt_en   <= 1'b0;
            cnt_rdb  <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (gnt0 || gnt1) begin
                        owner    <= gnt1;
                        cnt_din  <= gnt1 ? din1 : din0;
                        cnt_up   <= gnt1 ? up1 : up0;
                        cnt_load <= 1'b1;
                        busy     <= 1'b1;
                        state    <= StLoad;
                    end
                end
                StLoad: begin
                    cnt_load <= 1'b0;
                    cnt_en   <= 1'b1;
                    run_cnt  <= 9'd0;
                    state    <= StRun;
                end
                StRun: begin
                    run_cnt <= run_cnt_inc;
                    // Carry beats the watchdog when both land in the same cycle.
                    if (cnt_carry) begin
                        err_pend <= 1'b0;
                        cnt_en   <= 1'b0;
                        cnt_rdb  <= 1'b1;
                        state    <= StRead;
                    end else if (run_cnt_inc == WD_LIMIT) begin
                        err_pend <= 1'b1;
                        cnt_en   <= 1'b0;
                        cnt_rdb  <= 1'b1;
                        state    <= StRead;
                    end
                end
                StRead: begin
                    cnt_rdb <= 1'b0;
                    result  <= cnt_dout;
                    err     <= err_pend;
                    ack0    <= ~owner;
                    ack1    <= owner;
                    state   <= StDone;
                end
                StDone: begin
                    ptr   <= ~owner;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
